// File: rtl/prgm_dump_if.sv
// prgm_dump_if: program-memory read bus between the dump reader and prgm_mem.
//
// Bus protocol: there is no ready signal. The master holds mem_adrs stable.
// The slave presents mem_out for that address READ_WAIT cycles after
// mem_adrs changes. mem_out is only meaningful once that read latency has elapsed.
interface prgm_dump_if #(
   parameter int ADRS_W = 6,
   parameter int DATA_W = 8
);
   logic [ADRS_W-1:0] mem_adrs;
   logic [DATA_W-1:0] mem_out;

   modport master (output mem_adrs, input mem_out);
   modport slave  (input mem_adrs, output mem_out);
endinterface

// File: rtl/prgm_dump.sv
// prgm_dump: walks prgm_mem from start_adrs to end_adrs inclusive, wrapping at
// DEPTH. It shows each stored byte and its address on the display outputs.
// It advances on a timer (auto=1) or on a debounced step press. A debounced
// start event begins a dump from IDLE or DONE, and aborts a running dump.
// disp_valid pulses for one cycle with no backpressure. fsm_state exposes the
// FSM state for debug.
module prgm_dump #(
   parameter int ADRS_W     = 6,
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 64,
   parameter int READ_WAIT  = 2,
   parameter int DEBOUNCE   = 128,
   parameter int SCAN_TICKS = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              step,
   input  logic              auto,
   input  logic [ADRS_W-1:0] start_adrs,
   input  logic [ADRS_W-1:0] end_adrs,
   prgm_dump_if.master       mem,
   output logic              own,
   output logic              busy,
   output logic [DATA_W-1:0] disp_data,
   output logic [ADRS_W-1:0] disp_adrs,
   output logic              disp_valid,
   output logic              done,
   output logic [2:0]        fsm_state
);

   localparam int WAIT_W = (READ_WAIT < 4) ? 2 : $clog2(READ_WAIT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SET   = 3'd1,
      WAIT  = 3'd2,
      LATCH = 3'd3,
      HOLD  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t              state, state_nxt;
   logic [DEBOUNCE-1:0] start_sh, step_sh;
   logic                start_ev, step_ev;
   logic [ADRS_W-1:0]   cur, cur_nxt, cur_inc;
   logic [ADRS_W-1:0]   adrs_reg, adrs_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic [31:0]         timer, timer_nxt;
   logic                own_nxt, busy_nxt, done_nxt, valid_nxt;
   logic [DATA_W-1:0]   data_nxt;
   logic [ADRS_W-1:0]   dadrs_nxt;
   logic                tick_due;

   // An event is the one cycle where only the newest sample is high, so a
   // held switch or a short dropout on a held button cannot retrigger.
   assign start_ev = (start_sh == DEBOUNCE'(1));
   assign step_ev  = (step_sh == DEBOUNCE'(1));

   assign cur_inc  = (cur == ADRS_W'(DEPTH - 1)) ? '0 : cur + ADRS_W'(1);
   assign tick_due = auto && (timer == 32'(SCAN_TICKS - 1));

   assign mem.mem_adrs = adrs_reg;
   assign fsm_state    = state;

   // Debounce shift registers: shift left, newest sample in bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_sh <= '0;
         step_sh  <= '0;
      end else begin
         start_sh <= {start_sh[DEBOUNCE-2:0], start};
         step_sh  <= {step_sh[DEBOUNCE-2:0], step};
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cur        <= '0;
         adrs_reg   <= '0;
         wait_cnt   <= '0;
         timer      <= '0;
         own        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         disp_data  <= '0;
         disp_adrs  <= '0;
         disp_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         cur        <= cur_nxt;
         adrs_reg   <= adrs_nxt;
         wait_cnt   <= wait_nxt;
         timer      <= timer_nxt;
         own        <= own_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         disp_data  <= data_nxt;
         disp_adrs  <= dadrs_nxt;
         disp_valid <= valid_nxt;
      end
   end

   // Next state and next output values. In an active state, start takes
   // priority over everything and aborts the dump.
   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      adrs_nxt  = adrs_reg;
      wait_nxt  = wait_cnt;
      timer_nxt = timer;
      own_nxt   = own;
      busy_nxt  = busy;
      done_nxt  = done;
      data_nxt  = disp_data;
      dadrs_nxt = disp_adrs;
      valid_nxt = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start_ev) begin
               cur_nxt   = start_adrs;
               done_nxt  = 1'b0;
               busy_nxt  = 1'b1;
               own_nxt   = 1'b1;
               state_nxt = SET;
            end
         end
         SET, WAIT, LATCH, HOLD: begin
            if (start_ev) begin
               own_nxt   = 1'b0;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (state == SET) begin
               adrs_nxt  = cur;
               wait_nxt  = '0;
               state_nxt = WAIT;
            end else if (state == WAIT) begin
               if (wait_cnt == WAIT_W'(READ_WAIT - 1)) state_nxt = LATCH;
               else wait_nxt = wait_cnt + WAIT_W'(1);
            end else if (state == LATCH) begin
               data_nxt  = mem.mem_out;
               dadrs_nxt = cur;
               valid_nxt = 1'b1;
               timer_nxt = '0;
               state_nxt = HOLD;
            end else if (step_ev || tick_due) begin
               if (cur == end_adrs) begin
                  own_nxt   = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = DONE;
               end else begin
                  cur_nxt   = cur_inc;
                  state_nxt = SET;
               end
            end else if (auto) begin
               timer_nxt = timer + 32'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
